// File: rtl/edge_generator_pkg.sv
// Shared types and defaults for the edge generator.
package edge_generator_pkg;

    localparam int unsigned HOLD_W_DEFAULT = 8;

    // Output level in bit 1, hold counter running in bit 0.
    typedef enum logic [1:0] {
        LOW_IDLE  = 2'b00,
        LOW_HOLD  = 2'b01,
        HIGH_IDLE = 2'b10,
        HIGH_HOLD = 2'b11
    } edge_gen_state_t;

endpackage

// File: rtl/hold_counter.sv
// Loadable hold-time down-counter. A load of 0 or 1 both give a zero count,
// so the level holds for max(value,1) cycles; the counter never wraps.
module hold_counter
    import edge_generator_pkg::*;
#(
    parameter int unsigned HOLD_W = HOLD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [HOLD_W-1:0] value,
    output logic [HOLD_W-1:0] count,
    output logic [HOLD_W-1:0] count_next_c,
    output logic              zero_c
);

    // Next count: reload to max(value,1)-1, else decrement while nonzero.
    always_comb begin
        count_next_c = count;
        if (load) begin
            count_next_c = (value == '0) ? '0 : value - HOLD_W'(1);
        end else if (count != '0) begin
            count_next_c = count - HOLD_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else begin
            count <= count_next_c;
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/edge_generator.sv
// Edge generator: converts rise/fall request pulses into a registered level
// with programmable minimum high/low times and edge marker pulses.
// Optional one-deep pending slot: define EDGE_GENERATOR_PENDING_EN.
module edge_generator
    import edge_generator_pkg::*;
#(
    parameter int unsigned HOLD_W = HOLD_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rise_req_i,
    input  logic              fall_req_i,
    input  logic [HOLD_W-1:0] min_high_i,
    input  logic [HOLD_W-1:0] min_low_i,
    output logic              level_o,
    output logic              rise_o,
    output logic              fall_o,
    output logic              busy_o,
    output logic              drop_o
);

    edge_gen_state_t   state;
    edge_gen_state_t   state_next;
    logic              high_c;
    logic              want_up_c;
    logic              want_dn_c;
    logic              both_c;
    logic              opp_c;
    logic              go_c;
    logic              load_c;
    logic [HOLD_W-1:0] load_val_c;
    logic              level_next;
    logic              rise_next;
    logic              fall_next;
    logic              drop_next;
    logic [HOLD_W-1:0] count;
    logic [HOLD_W-1:0] count_next_c;
    logic              zero_c;
    logic              pend_q;
`ifdef EDGE_GENERATOR_PENDING_EN
    logic              pend_next;
`else
    assign pend_q = 1'b0;
`endif

    hold_counter #(
        .HOLD_W (HOLD_W)
    ) u_hold_counter (
        .clk          (clk),
        .reset        (reset),
        .load         (load_c),
        .value        (load_val_c),
        .count        (count),
        .count_next_c (count_next_c),
        .zero_c       (zero_c)
    );

    assign high_c    = (state == HIGH_IDLE) || (state == HIGH_HOLD);
    assign want_up_c = rise_req_i & ~fall_req_i;
    assign want_dn_c = fall_req_i & ~rise_req_i;
    assign both_c    = rise_req_i & fall_req_i;
    assign opp_c     = high_c ? want_dn_c : want_up_c;

    // Request arbitration: accept, park, ignore or drop; choose the reload value.
    always_comb begin
        go_c       = 1'b0;
        load_c     = 1'b0;
        load_val_c = min_high_i;
        level_next = high_c;
        rise_next  = 1'b0;
        fall_next  = 1'b0;
        drop_next  = both_c;
`ifdef EDGE_GENERATOR_PENDING_EN
        pend_next  = pend_q;
`endif
        if (zero_c) begin
            go_c = opp_c | pend_q;
`ifdef EDGE_GENERATOR_PENDING_EN
            pend_next = 1'b0;
`endif
        end else if (opp_c) begin
`ifdef EDGE_GENERATOR_PENDING_EN
            if (pend_q) begin
                drop_next = 1'b1;
            end else begin
                pend_next = 1'b1;
            end
`else
            drop_next = 1'b1;
`endif
        end
        if (go_c) begin
            load_c     = 1'b1;
            load_val_c = high_c ? min_low_i : min_high_i;
            level_next = ~high_c;
            rise_next  = ~high_c;
            fall_next  = high_c;
        end
    end

    // Next state follows the new level and whether the hold counter will run.
    always_comb begin
        state_next = state;
        case ({level_next, (count_next_c != '0)})
            2'b00:   state_next = LOW_IDLE;
            2'b01:   state_next = LOW_HOLD;
            2'b10:   state_next = HIGH_IDLE;
            default: state_next = HIGH_HOLD;
        endcase
    end

    // State and registered outputs; reset forces low without a fall marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= LOW_IDLE;
            level_o <= 1'b0;
            rise_o  <= 1'b0;
            fall_o  <= 1'b0;
            busy_o  <= 1'b0;
            drop_o  <= 1'b0;
        end else begin
            state   <= state_next;
            level_o <= level_next;
            rise_o  <= rise_next;
            fall_o  <= fall_next;
            busy_o  <= (count_next_c != '0);
            drop_o  <= drop_next;
        end
    end

`ifdef EDGE_GENERATOR_PENDING_EN
    // One-deep pending request slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q <= 1'b0;
        end else begin
            pend_q <= pend_next;
        end
    end
`endif

endmodule

// File: tb/tb_edge_generator.sv
// Randomized self-checking bench for edge_generator against a cycle model
// that tracks the level, remaining hold cycles and the pending request.
module tb_edge_generator;

    localparam int unsigned HOLD_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              rise_req_i = 1'b0;
    logic              fall_req_i = 1'b0;
    logic [HOLD_W-1:0] min_high_i = '0;
    logic [HOLD_W-1:0] min_low_i = '0;
    logic              level_o;
    logic              rise_o;
    logic              fall_o;
    logic              busy_o;
    logic              drop_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    bit m_level = 0;
    int m_rem   = 0;
    bit m_pend  = 0;
    bit m_rise  = 0;
    bit m_fall  = 0;
    bit m_drop  = 0;

    edge_generator #(.HOLD_W(HOLD_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .rise_req_i (rise_req_i),
        .fall_req_i (fall_req_i),
        .min_high_i (min_high_i),
        .min_low_i  (min_low_i),
        .level_o    (level_o),
        .rise_o     (rise_o),
        .fall_o     (fall_o),
        .busy_o     (busy_o),
        .drop_o     (drop_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock of the reference model, using the inputs currently applied.
    task automatic model_step();
        bit up, dn, opp, go;
        int n;
        if (reset) begin
            m_level = 0; m_rem = 0; m_pend = 0;
            m_rise = 0; m_fall = 0; m_drop = 0;
            return;
        end
        up   = rise_req_i && !fall_req_i;
        dn   = fall_req_i && !rise_req_i;
        opp  = m_level ? dn : up;
        go   = 0;
        m_drop = rise_req_i && fall_req_i;
        if (m_rem == 0) begin
            go = opp || m_pend;
            m_pend = 0;
        end else begin
            m_rem = m_rem - 1;
            if (opp) begin
`ifdef EDGE_GENERATOR_PENDING_EN
                if (m_pend) m_drop = 1;
                else        m_pend = 1;
`else
                m_drop = 1;
`endif
            end
        end
        m_rise = 0;
        m_fall = 0;
        if (go) begin
            m_level = !m_level;
            m_rise  = m_level;
            m_fall  = !m_level;
            n = m_level ? int'(min_high_i) : int'(min_low_i);
            if (n < 1) n = 1;
            m_rem = n - 1;
        end
    endtask

    // Apply inputs for one cycle, advance the model, compare at the falling edge.
    task automatic cyc(input bit rst, input bit rr, input bit fr,
                       input logic [HOLD_W-1:0] mh, input logic [HOLD_W-1:0] ml);
        reset      = rst;
        rise_req_i = rr;
        fall_req_i = fr;
        min_high_i = mh;
        min_low_i  = ml;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("level", 32'(level_o), 32'(m_level));
        check("rise",  32'(rise_o),  32'(m_rise));
        check("fall",  32'(fall_o),  32'(m_fall));
        check("busy",  32'(busy_o),  32'(m_rem != 0));
        check("drop",  32'(drop_o),  32'(m_drop));
        check("rise_fall_excl", 32'(rise_o & fall_o), 32'(0));
    endtask

    initial begin
        bit rr, fr;
        logic [HOLD_W-1:0] mh, ml;

        // Reset state.
        cyc(1, 0, 0, 3, 3);
        cyc(1, 0, 0, 3, 3);
        check("rst_level", 32'(level_o), 32'(0));
        check("rst_busy",  32'(busy_o),  32'(0));

        // Rise with min_high=3, then fall as soon as the hold expires.
        cyc(0, 0, 0, 3, 3);
        cyc(0, 1, 0, 3, 3);
        check("rise_level", 32'(level_o), 32'(1));
        check("rise_pulse", 32'(rise_o),  32'(1));
        check("rise_busy0", 32'(busy_o),  32'(1));
        cyc(0, 0, 0, 3, 3);
        check("rise_busy1", 32'(busy_o),  32'(1));
        cyc(0, 0, 0, 3, 3);
        check("rise_busy2", 32'(busy_o),  32'(0));
        cyc(0, 0, 1, 3, 3);
        check("fall_level", 32'(level_o), 32'(0));
        check("fall_pulse", 32'(fall_o),  32'(1));

        // Early fall during hold: dropped or parked depending on the build.
        cyc(0, 0, 0, 3, 3);
        cyc(0, 0, 0, 3, 3);
        cyc(0, 1, 0, 3, 3);
        cyc(0, 1, 0, 3, 3);
        cyc(0, 0, 1, 3, 3);
        cyc(0, 0, 0, 3, 3);
        cyc(0, 0, 0, 3, 3);
        cyc(0, 1, 0, 3, 3);
        cyc(0, 1, 0, 3, 3);

        // Both requests together in low idle: dropped, level stays low.
        cyc(0, 0, 1, 1, 1);
        cyc(0, 0, 0, 1, 1);
        cyc(0, 1, 1, 1, 1);
        check("both_drop",  32'(drop_o),  32'(1));
        check("both_level", 32'(level_o), 32'(0));
        check("both_rise",  32'(rise_o),  32'(0));

        // Zero hold times: alternate requests toggle every cycle, no drops.
        for (int i = 0; i < 10; i++) begin
            cyc(0, (i % 2) == 0, (i % 2) == 1, 0, 0);
            check("tog_level", 32'(level_o), 32'((i % 2) == 0));
            check("tog_drop",  32'(drop_o),  32'(0));
        end

        // Reset while high and busy: forced low without a fall marker.
        cyc(0, 0, 0, 5, 5);
        cyc(0, 1, 0, 5, 5);
        cyc(0, 0, 1, 5, 5);
        cyc(1, 0, 0, 5, 5);
        check("rsthi_level", 32'(level_o), 32'(0));
        check("rsthi_fall",  32'(fall_o),  32'(0));
        check("rsthi_busy",  32'(busy_o),  32'(0));
        cyc(0, 1, 0, 2, 2);
        check("rsthi_rise", 32'(level_o), 32'(1));

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            rr = ($urandom_range(0, 99) < 35);
            fr = ($urandom_range(0, 99) < 35);
            mh = ($urandom_range(0, 3) == 0) ? HOLD_W'($urandom_range(0, 12)) : HOLD_W'($urandom_range(0, 3));
            ml = ($urandom_range(0, 3) == 0) ? HOLD_W'($urandom_range(0, 12)) : HOLD_W'($urandom_range(0, 3));
            cyc($urandom_range(0, 149) == 0, rr, fr, mh, ml);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
